// File: rtl/fifo19_txrealign_pkg.sv
// Shared fifo19 line encoding and the TX realigner state encoding.
package fifo19_txrealign_pkg;

    localparam int unsigned F19_W   = 19;
    localparam int unsigned SOF_BIT = 16;
    localparam int unsigned EOF_BIT = 17;
    localparam int unsigned OCC_BIT = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_PASS,
        ST_PAD
    } state_t;

endpackage

// File: rtl/fifo19_txrealign.sv
// Strips the leading 16-bit alignment pad of each TX frame, re-marks SOF on the
// first real line and zero-pads short frames up to MIN_LINES output lines.
module fifo19_txrealign
    import fifo19_txrealign_pkg::*;
#(
    parameter int unsigned MIN_LINES = 30,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [18:0]      datain,
    input  logic             src_rdy_i,
    output logic             dst_rdy_o,
    output logic [18:0]      dataout,
    output logic             src_rdy_o,
    input  logic             dst_rdy_i,
    output logic [CNT_W-1:0] runt_drops
);

    localparam logic [CNT_W:0] MIN_L = (CNT_W+1)'(MIN_LINES);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] runt, runt_nxt;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic             short_eof;

    // cnt_inc is one bit wider so the MIN_LINES compare never wraps.
    assign cnt_inc    = {1'b0, cnt} + (CNT_W+1)'(1);
    assign cnt_sat    = (&cnt) ? cnt : cnt_inc[CNT_W-1:0];
    assign runt_drops = runt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        runt_nxt  = runt;
        dataout   = '0;
        src_rdy_o = 1'b0;
        dst_rdy_o = 1'b1;
        short_eof = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (src_rdy_i && datain[SOF_BIT]) begin
                    if (datain[EOF_BIT])
                        runt_nxt = (&runt) ? runt : runt + CNT_W'(1);
                    else
                        state_nxt = ST_FIRST;
                end
            end
            ST_FIRST, ST_PASS: begin
                dataout          = datain;
                dataout[SOF_BIT] = (state == ST_FIRST);
                src_rdy_o        = src_rdy_i;
                dst_rdy_o        = dst_rdy_i;
                short_eof        = datain[EOF_BIT] && (cnt_inc < MIN_L);
                // A short frame's last line is not the end of the output frame.
                if (short_eof) begin
                    dataout[EOF_BIT] = 1'b0;
                    dataout[OCC_BIT] = 1'b0;
                end
                if (src_rdy_i && dst_rdy_i) begin
                    cnt_nxt   = cnt_sat;
                    state_nxt = ST_PASS;
                    if (datain[EOF_BIT]) begin
                        if (short_eof) begin
                            state_nxt = ST_PAD;
                        end else begin
                            state_nxt = ST_IDLE;
                            cnt_nxt   = '0;
                        end
                    end
                end
            end
            ST_PAD: begin
                dst_rdy_o        = 1'b0;
                src_rdy_o        = 1'b1;
                dataout[EOF_BIT] = (cnt_inc == MIN_L);
                if (dst_rdy_i) begin
                    cnt_nxt = cnt_sat;
                    if (cnt_inc == MIN_L) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            runt  <= '0;
        end else if (clear) begin
            state <= ST_IDLE;
            cnt   <= '0;
            runt  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            runt  <= runt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo19_txrealign.sv
// Directed and randomised-handshake bench for the TX realigner.
module tb_fifo19_txrealign;

    localparam int MIN = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [18:0] datain = '0;
    logic        src_rdy_i = 1'b0;
    logic        dst_rdy_o;
    logic [18:0] dataout;
    logic        src_rdy_o;
    logic        dst_rdy_i = 1'b0;
    logic [15:0] runt_drops;

    int errors = 0;
    int checks = 0;

    logic [18:0] in_q[$];
    logic [18:0] out_q[$];
    logic [18:0] exp_q[$];

    fifo19_txrealign #(.MIN_LINES(30), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .datain(datain), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o),
        .dataout(dataout), .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy_i),
        .runt_drops(runt_drops)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] w(input bit sof, input bit eof, input bit occ,
                                      input logic [15:0] d);
        return {occ, eof, sof, d};
    endfunction

    // Drives in_q upstream and captures downstream transfers into out_q.
    task automatic run_stream(input int src_pct, input int dst_pct, input int max_cycles,
                              output bit timed_out);
        int idle = 0;
        int cyc = 0;
        timed_out = 1'b0;
        while (idle < 4) begin
            if (cyc >= max_cycles) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (in_q.size() > 0 && int'($urandom_range(99)) < src_pct) begin
                src_rdy_i = 1'b1;
                datain    = in_q[0];
            end else begin
                src_rdy_i = 1'b0;
                datain    = '0;
            end
            dst_rdy_i = (int'($urandom_range(99)) < dst_pct);
            @(negedge clk);
            if (src_rdy_o && dst_rdy_i) out_q.push_back(dataout);
            if (src_rdy_i && dst_rdy_o) void'(in_q.pop_front());
            if (in_q.size() == 0 && !src_rdy_o) idle++;
            else idle = 0;
            cyc++;
        end
        @(posedge clk); #1;
        src_rdy_i = 1'b0;
        datain    = '0;
        dst_rdy_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (src_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_src_rdy got=%b exp=0", src_rdy_o); end
        checks++; if (dst_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_dst_rdy got=%b exp=1", dst_rdy_o); end
        checks++; if (dataout !== 19'h0) begin errors++; $display("FAIL reset_dataout got=%h exp=0", dataout); end
        checks++; if (runt_drops !== 16'd0) begin errors++; $display("FAIL reset_runt got=%0d exp=0", runt_drops); end
        reset = 1'b0;
    endtask

    task automatic test_long_frame();
        bit to;
        int bad = -1;
        in_q.delete(); out_q.delete();
        in_q.push_back(w(1, 0, 0, 16'hDEAD));
        for (int i = 1; i <= 39; i++) in_q.push_back(w(0, i == 39, 0, 16'(i)));
        run_stream(100, 100, 500, to);
        checks++; if (to) begin errors++; $display("FAIL long_timeout got=timeout exp=done"); end
        checks++; if (out_q.size() != 39) begin errors++; $display("FAIL long_len got=%0d exp=39", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 39; i++)
            if (bad < 0 && out_q[i] !== w(i == 0, i == 38, 0, 16'(i + 1))) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL long_line%0d got=%h exp=%h", bad, out_q[bad], w(bad == 0, bad == 38, 0, 16'(bad + 1))); end
    endtask

    task automatic test_short_frame();
        bit to;
        int bad = -1;
        logic [15:0] d[4] = '{16'hA1A1, 16'hA2A2, 16'hA3A3, 16'hA4A4};
        in_q.delete(); out_q.delete(); exp_q.delete();
        in_q.push_back(w(1, 0, 0, 16'h0BAD));
        for (int i = 0; i < 4; i++) in_q.push_back(w(0, i == 3, 0, d[i]));
        for (int i = 0; i < 4; i++) exp_q.push_back(w(i == 0, 0, 0, d[i]));
        for (int i = 4; i < 30; i++) exp_q.push_back(w(0, i == 29, 0, 16'h0000));
        run_stream(100, 100, 500, to);
        checks++; if (to) begin errors++; $display("FAIL short_timeout got=timeout exp=done"); end
        checks++; if (out_q.size() != 30) begin errors++; $display("FAIL short_len got=%0d exp=30", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 30; i++)
            if (bad < 0 && out_q[i] !== exp_q[i]) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL short_line%0d got=%h exp=%h", bad, out_q[bad], exp_q[bad]); end
    endtask

    task automatic test_odd_frame();
        bit to;
        int bad = -1;
        in_q.delete(); out_q.delete(); exp_q.delete();
        in_q.push_back(w(1, 0, 0, 16'hFFFF));
        in_q.push_back(w(0, 0, 0, 16'h1111));
        in_q.push_back(w(0, 1, 1, 16'h22AB));
        exp_q.push_back(w(1, 0, 0, 16'h1111));
        exp_q.push_back(w(0, 0, 0, 16'h22AB));
        for (int i = 2; i < 30; i++) exp_q.push_back(w(0, i == 29, 0, 16'h0000));
        run_stream(100, 40, 800, to);
        checks++; if (to) begin errors++; $display("FAIL odd_timeout got=timeout exp=done"); end
        checks++; if (out_q.size() != 30) begin errors++; $display("FAIL odd_len got=%0d exp=30", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 30; i++)
            if (bad < 0 && out_q[i] !== exp_q[i]) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL odd_line%0d got=%h exp=%h", bad, out_q[bad], exp_q[bad]); end
    endtask

    task automatic test_runt_back_to_back();
        bit to;
        int bad = -1;
        checks++; if (runt_drops !== 16'd0) begin errors++; $display("FAIL runt_start got=%0d exp=0", runt_drops); end
        in_q.delete(); out_q.delete();
        in_q.push_back(w(1, 1, 0, 16'h1234));
        in_q.push_back(w(1, 0, 0, 16'h0000));
        for (int i = 1; i <= 39; i++) in_q.push_back(w(0, i == 39, 0, 16'h7000 + 16'(i)));
        run_stream(100, 100, 500, to);
        checks++; if (to) begin errors++; $display("FAIL runt_timeout got=timeout exp=done"); end
        checks++; if (runt_drops !== 16'd1) begin errors++; $display("FAIL runt_count got=%0d exp=1", runt_drops); end
        checks++; if (out_q.size() != 39) begin errors++; $display("FAIL runt_next_len got=%0d exp=39", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 39; i++)
            if (bad < 0 && out_q[i] !== w(i == 0, i == 38, 0, 16'h7001 + 16'(i))) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL runt_next_line%0d got=%h exp=%h", bad, out_q[bad], w(bad == 0, bad == 38, 0, 16'h7001 + 16'(bad))); end
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        checks++; if (runt_drops !== 16'd0) begin errors++; $display("FAIL clear_runt got=%0d exp=0", runt_drops); end
    endtask

    task automatic test_boundaries();
        bit to;
        int bad = -1;
        in_q.delete(); out_q.delete(); exp_q.delete();
        in_q.push_back(w(0, 0, 0, 16'h5555));
        in_q.push_back(w(0, 1, 1, 16'h5656));
        in_q.push_back(w(1, 0, 0, 16'h0000));
        for (int i = 1; i <= 30; i++) in_q.push_back(w(0, i == 30, i == 30, 16'h3000 + 16'(i)));
        in_q.push_back(w(1, 0, 0, 16'h0000));
        in_q.push_back(w(0, 1, 1, 16'hBEEF));
        for (int i = 1; i <= 30; i++) exp_q.push_back(w(i == 1, i == 30, i == 30, 16'h3000 + 16'(i)));
        exp_q.push_back(w(1, 0, 0, 16'hBEEF));
        for (int i = 1; i < 30; i++) exp_q.push_back(w(0, i == 29, 0, 16'h0000));
        run_stream(100, 100, 500, to);
        checks++; if (to) begin errors++; $display("FAIL bound_timeout got=timeout exp=done"); end
        checks++; if (out_q.size() != 60) begin errors++; $display("FAIL bound_len got=%0d exp=60", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 60; i++)
            if (bad < 0 && out_q[i] !== exp_q[i]) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL bound_line%0d got=%h exp=%h", bad, out_q[bad], exp_q[bad]); end
    endtask

    task automatic test_random();
        bit to;
        int bad = -1;
        int frames = 0;
        int struct_bad = 0;
        int flen = 0;
        bit in_frame = 1'b0;
        in_q.delete(); out_q.delete(); exp_q.delete();
        for (int f = 0; f < 200; f++) begin
            int n = int'($urandom_range(100, 2));
            int nd = n - 1;
            bit last_occ = 1'($urandom_range(1));
            logic [15:0] d;
            in_q.push_back(w(1, 0, 0, 16'($urandom)));
            for (int i = 1; i <= nd; i++) begin
                d = 16'($urandom);
                in_q.push_back(w((i != 1) && ($urandom_range(9) == 0), i == nd, (i == nd) && last_occ, d));
                if (nd >= MIN) exp_q.push_back(w(i == 1, i == nd, (i == nd) && last_occ, d));
                else exp_q.push_back(w(i == 1, 0, 0, d));
            end
            for (int k = nd + 1; k <= MIN; k++) exp_q.push_back(w(0, k == MIN, 0, 16'h0000));
        end
        run_stream(70, 50, 60000, to);
        checks++; if (to) begin errors++; $display("FAIL rand_timeout got=timeout exp=done"); end
        checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_len got=%0d exp=%0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            if (bad < 0 && out_q[i] !== exp_q[i]) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL rand_line%0d got=%h exp=%h", bad, out_q[bad], exp_q[bad]); end
        foreach (out_q[i]) begin
            if (out_q[i][16] == in_frame) struct_bad++;
            in_frame = 1'b1;
            flen++;
            if (out_q[i][17]) begin
                if (flen < MIN) struct_bad++;
                frames++;
                flen = 0;
                in_frame = 1'b0;
            end
        end
        checks++; if (struct_bad != 0 || frames != 200) begin errors++; $display("FAIL rand_framing got=%0d_bad_%0d_frames exp=0_bad_200_frames", struct_bad, frames); end
    endtask

    task automatic test_mid_frame_reset();
        bit to;
        int bad = -1;
        in_q.delete(); out_q.delete();
        in_q.push_back(w(1, 0, 0, 16'h0000));
        for (int i = 1; i <= 9; i++) in_q.push_back(w(0, 0, 0, 16'h0200 + 16'(i)));
        run_stream(100, 100, 200, to);
        checks++; if (to || out_q.size() != 9) begin errors++; $display("FAIL partial_len got=%0d exp=9", out_q.size()); end
        #3 reset = 1'b1;
        @(negedge clk);
        checks++; if (src_rdy_o !== 1'b0 || dst_rdy_o !== 1'b1) begin errors++; $display("FAIL midreset_rdy got=%b%b exp=01", src_rdy_o, dst_rdy_o); end
        @(posedge clk); #1 reset = 1'b0;
        out_q.delete();
        in_q.push_back(w(1, 0, 0, 16'h0000));
        for (int i = 1; i <= 39; i++) in_q.push_back(w(0, i == 39, 0, 16'h0500 + 16'(i)));
        run_stream(100, 100, 500, to);
        checks++; if (to || out_q.size() != 39) begin errors++; $display("FAIL after_reset_len got=%0d exp=39", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 39; i++)
            if (bad < 0 && out_q[i] !== w(i == 0, i == 38, 0, 16'h0501 + 16'(i))) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL after_reset_line%0d got=%h exp=%h", bad, out_q[bad], w(bad == 0, bad == 38, 0, 16'h0501 + 16'(bad))); end
        checks++; if (runt_drops !== 16'd0) begin errors++; $display("FAIL after_reset_runt got=%0d exp=0", runt_drops); end
    endtask

    initial begin
        test_reset();
        test_long_frame();
        test_short_frame();
        test_odd_frame();
        test_runt_back_to_back();
        test_boundaries();
        test_random();
        test_mid_frame_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
